// File: rtl/instr_fetch.sv
// Instruction fetch: issues PC-driven reads to a synchronous instruction memory and queues responses in a small FIFO.
// Optional build macro INSTR_FETCH_PERF_EN adds a saturating credit-stall counter output.
module instr_fetch #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    pc,
    output logic               pc_en,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               halt,
    input  logic               flush,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    output logic               idle
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic                r_inflight;
    logic [PC_W-1:0]     r_inflight_pc;
    logic                r_flush_d;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [INSTR_W-1:0]  r_data [DEPTH];
    logic [PC_W-1:0]     r_pcs  [DEPTH];

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [CW:0]         w_credit;

    // Credit counts the outstanding fetch so a returning word always has a free slot.
    assign w_credit    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue     = (r_state == S_RUN) && !halt && !flush && (w_credit < DEPTH_C);
    assign w_push      = r_inflight && !flush && !r_flush_d;
    assign w_pop       = instr_valid && instr_ready;

    assign pc_en       = w_issue;
    assign imem_rd     = w_issue;
    assign imem_addr   = pc;
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_data[r_rptr];
    assign instr_pc    = r_pcs[r_rptr];
    assign idle        = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_flush_d     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_flush_d  <= flush;
            if (w_issue) begin
                r_inflight_pc <= pc;
            end
            // Flush freezes the state machine, but a drain has nothing left to wait for.
            if (flush) begin
                if (r_state == S_DRAIN) begin
                    r_state <= S_IDLE;
                end
            end else begin
                unique case (r_state)
                    S_IDLE:  if (!halt) r_state <= S_RUN;
                    S_RUN:   if (halt) r_state <= S_DRAIN;
                    S_DRAIN: begin
                        if (!halt) begin
                            r_state <= S_RUN;
                        end else if (!r_inflight && (r_count == '0)) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pcs[i]  <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= imem_rdata;
                r_pcs[r_wptr]  <= r_inflight_pc;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !halt && !flush && !w_issue && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory/PC models plus an output scoreboard fed with hand-derived PC sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  pc = '0;
    logic        pc_en;
    logic [8:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata = '0;
    logic        halt = 1'b0;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_data;
    logic [8:0]  instr_pc;
    logic        idle;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] stall_cnt;
`endif

    logic        pc_load = 1'b0;
    logic [8:0]  pc_load_val = '0;
    logic [8:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;

    instr_fetch #(.PC_W(9), .INSTR_W(32), .DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pc(pc),
        .pc_en(pc_en),
        .imem_addr(imem_addr),
        .imem_rd(imem_rd),
        .imem_rdata(imem_rdata),
        .halt(halt),
        .flush(flush),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .idle(idle)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Synchronous-read ROM holding A000_0000 + address, and a PC counter advanced by pc_en.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= 32'hA000_0000 + 32'(imem_addr);
        if (pc_load) pc <= pc_load_val;
        else if (pc_en) pc <= pc + 9'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (!idle && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_idle", 32'(idle), 32'd1);
    endtask

    // Monitor: head entry must match the expected front every valid cycle; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (dut.w_push) chk("push_not_full", 32'(dut.r_count < 3'd4), 32'd1);
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pc %0d expected none at %0t", instr_pc, $time);
                end else begin
                    chk("out_pc", 32'(instr_pc), 32'(exp_q[0]));
                    chk("out_data", instr_data, 32'hA000_0000 + 32'(exp_q[0]));
                    if (instr_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_imem_rd", 32'(imem_rd), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", instr_data, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);

        // Reset then stream: 7 issues (pc 0..6), halt on the 8th cycle
        for (int i = 0; i < 7; i++) exp_q.push_back(9'(i));
        step(); step(); step();
        reset_n = 1'b1;
        #1;
        chk("a_idle_first", 32'(idle), 32'd1);
        chk("a_no_issue_idle", 32'(pc_en), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step();
            #1;
            chk("a_pc_en", 32'(pc_en), 32'd1);
            chk("a_addr", 32'(imem_addr), 32'(k - 1));
            if (k == 2) chk("a_valid_lat1", 32'(instr_valid), 32'd0);
            if (k == 3) chk("a_valid_lat2", 32'(instr_valid), 32'd1);
        end
        step();
        halt = 1'b1;
        #1;
        chk("a_halt_now", 32'(pc_en), 32'd0);
        wait_idle(20);
        chk("a_all_out", 32'(exp_q.size()), 32'd0);

        // Backpressure: exactly 4 issues (7..10), then release and halt with count=2, inflight=1
        step();
        halt = 1'b0;
        instr_ready = 1'b0;
        for (int i = 7; i <= 11; i++) exp_q.push_back(9'(i));
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            chk("b_pc_en", 32'(pc_en), 32'(k <= 4));
            if (k == 1) chk("b_first_addr", 32'(imem_addr), 32'd7);
        end
        chk("b_hold_valid", 32'(instr_valid), 32'd1);
        chk("b_hold_pc", 32'(instr_pc), 32'd7);
        step();
        instr_ready = 1'b1;
        #1;
        chk("b_full_no_issue", 32'(pc_en), 32'd0);
        step();
        #1;
        chk("b_resume_en", 32'(pc_en), 32'd1);
        chk("b_resume_addr", 32'(imem_addr), 32'd11);
        step();
        halt = 1'b1;
        #1;
        chk("c_halt_no_issue", 32'(pc_en), 32'd0);
        wait_idle(20);
        chk("c_drained", 32'(exp_q.size()), 32'd0);

        // Resume, then flush with count=3 and pc 15 in flight
        step();
        halt = 1'b0;
        instr_ready = 1'b0;
        for (int i = 12; i <= 14; i++) exp_q.push_back(9'(i));
        for (int k = 1; k <= 4; k++) begin
            step();
            #1;
            chk("d_pc_en", 32'(pc_en), 32'd1);
            chk("d_addr", 32'(imem_addr), 32'(11 + k));
        end
        step();
        flush = 1'b1;
        #1;
        chk("d_flush_no_issue", 32'(pc_en), 32'd0);
        chk("d_flush_valid", 32'(instr_valid), 32'd1);
        step();
        flush = 1'b0;
        instr_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(9'd16);
        exp_q.push_back(9'd17);
        #1;
        chk("d_after_flush_valid", 32'(instr_valid), 32'd0);
        chk("d_after_flush_en", 32'(pc_en), 32'd1);
        chk("d_after_flush_addr", 32'(imem_addr), 32'd16);
        step();
        #1;
        chk("d_addr17", 32'(imem_addr), 32'd17);
        step();
        halt = 1'b1;
        #1;
        chk("d_halt", 32'(pc_en), 32'd0);
        wait_idle(20);
        chk("d_drained", 32'(exp_q.size()), 32'd0);

        // PC wrap: 510, 511, 0, 1
        step();
        pc_load = 1'b1;
        pc_load_val = 9'd510;
        step();
        pc_load = 1'b0;
        halt = 1'b0;
        exp_q.push_back(9'd510);
        exp_q.push_back(9'd511);
        exp_q.push_back(9'd0);
        exp_q.push_back(9'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk("e_addr", 32'(imem_addr), (32'd510 + 32'(k)) % 32'd512);
        end
        step();
        halt = 1'b1;
        #1;
        chk("e_halt", 32'(pc_en), 32'd0);
        wait_idle(20);
        chk("e_drained", 32'(exp_q.size()), 32'd0);

        // Async reset with count=2 and a fetch in flight; restart from pc 100
        step();
        halt = 1'b0;
        instr_ready = 1'b0;
        exp_q.push_back(9'd2);
        exp_q.push_back(9'd3);
        for (int k = 1; k <= 4; k++) begin
            step();
            #1;
            chk("f_addr", 32'(imem_addr), 32'(1 + k));
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("f_rst_pc_en", 32'(pc_en), 32'd0);
        chk("f_rst_imem_rd", 32'(imem_rd), 32'd0);
        chk("f_rst_valid", 32'(instr_valid), 32'd0);
        chk("f_rst_data", instr_data, 32'd0);
        chk("f_rst_pc", 32'(instr_pc), 32'd0);
        chk("f_rst_idle", 32'(idle), 32'd1);
        exp_q.delete();
        pc_load = 1'b1;
        pc_load_val = 9'd100;
        step();
        pc_load = 1'b0;
        instr_ready = 1'b1;
        exp_q.push_back(9'd100);
        exp_q.push_back(9'd101);
        step();
        reset_n = 1'b1;
        step();
        #1;
        chk("f_restart_en", 32'(pc_en), 32'd1);
        chk("f_restart_addr", 32'(imem_addr), 32'd100);
        step();
        #1;
        chk("f_addr101", 32'(imem_addr), 32'd101);
        step();
        halt = 1'b1;
        #1;
        chk("f_halt", 32'(pc_en), 32'd0);
        wait_idle(20);
        chk("f_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
